// File: rtl/div_sequencer.sv
// div_sequencer: control FSM for the 32-iteration shift-subtract divider.
//
// A one-cycle ctrl_DIV request starts a divide. It can also abort and restart
// one that is already running. The FSM walks IDLE -> LOAD -> ITER (x ITERATIONS)
// -> DONE. A zero divisor goes straight from LOAD to DONE.
//
// Ports
//   clock, reset         rising-edge clock, async active-high reset
//   ctrl_DIV             start / restart pulse
//   signA, signB         operand sign bits, valid with ctrl_DIV
//   divisorIsZero        divisor == 0, valid with ctrl_DIV
//   bootUp               datapath load strobe (LOAD)
//   iterEn               shift-subtract update enable (ITER)
//   iterCount            iteration index, 0 outside ITER
//   busy                 LOAD or ITER
//   negateQuotient       captured signA ^ signB
//   negateRemainder      captured signA
//   data_resultRDY       one-cycle completion pulse (DONE)
//   data_exception       divide-by-zero, only during DONE
module div_sequencer #(
  parameter int ITERATIONS = 32,
  parameter int CNT_W      = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic             signA,
  input  logic             signB,
  input  logic             divisorIsZero,
  output logic             bootUp,
  output logic             iterEn,
  output logic [CNT_W-1:0] iterCount,
  output logic             busy,
  output logic             negateQuotient,
  output logic             negateRemainder,
  output logic             data_resultRDY,
  output logic             data_exception
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERATIONS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             nq_q, nr_q, zero_q;

  // A request in any state wins. It recaptures the flags and re-enters LOAD,
  // so an aborted divide never reaches DONE.
  // The counter is held at 0 except while the FSM stays in ITER.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else if (ctrl_DIV) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      nq_q    <= signA ^ signB;
      nr_q    <= signA;
      zero_q  <= divisorIsZero;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        LOAD: begin
          state_q <= zero_q ? DONE : ITER;
          cnt_q   <= '0;
        end
        ITER: begin
          if (cnt_q == LAST) begin
            state_q <= DONE;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Moore decode: every strobe comes from the state register only.
  assign bootUp          = (state_q == LOAD);
  assign iterEn          = (state_q == ITER);
  assign busy            = (state_q == LOAD) || (state_q == ITER);
  assign data_resultRDY  = (state_q == DONE);
  assign data_exception  = (state_q == DONE) && zero_q;
  assign iterCount       = cnt_q;
  assign negateQuotient  = nq_q;
  assign negateRemainder = nr_q;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
  logic       clock = 1'b0;
  logic       reset, ctrl_DIV, signA, signB, divisorIsZero;
  logic       bootUp, iterEn, busy, negateQuotient, negateRemainder;
  logic       data_resultRDY, data_exception;
  logic [4:0] iterCount;

  int n_chk  = 0;
  int n_fail = 0;

  div_sequencer #(.ITERATIONS(32), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .ctrl_DIV(ctrl_DIV), .signA(signA),
    .signB(signB), .divisorIsZero(divisorIsZero), .bootUp(bootUp),
    .iterEn(iterEn), .iterCount(iterCount), .busy(busy),
    .negateQuotient(negateQuotient), .negateRemainder(negateRemainder),
    .data_resultRDY(data_resultRDY), .data_exception(data_exception)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive a request for one cycle (cycle N). Return in cycle N+1.
  task automatic start(input logic a, input logic b, input logic z);
    ctrl_DIV = 1'b1; signA = a; signB = b; divisorIsZero = z;
    tick();
    ctrl_DIV = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".bootUp"}, bootUp, 0);
    chk({tag, ".iterEn"}, iterEn, 0);
    chk({tag, ".iterCount"}, iterCount, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".nq"}, negateQuotient, 0);
    chk({tag, ".nr"}, negateRemainder, 0);
    chk({tag, ".rdy"}, data_resultRDY, 0);
    chk({tag, ".exc"}, data_exception, 0);
  endtask

  // Called in cycle N+1. Walks the whole non-zero divide through DONE and one
  // IDLE cycle, checking every strobe and the held sign flags.
  task automatic run_full(input string tag, input logic nq, input logic nr);
    chk({tag, ".load.bootUp"}, bootUp, 1);
    chk({tag, ".load.busy"}, busy, 1);
    chk({tag, ".load.iterEn"}, iterEn, 0);
    chk({tag, ".load.cnt"}, iterCount, 0);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk({tag, ".iter.iterEn"}, iterEn, 1);
      chk({tag, ".iter.bootUp"}, bootUp, 0);
      chk({tag, ".iter.cnt"}, iterCount, i);
      chk({tag, ".iter.rdy"}, data_resultRDY, 0);
      chk({tag, ".iter.nq"}, negateQuotient, nq);
      chk({tag, ".iter.nr"}, negateRemainder, nr);
    end
    tick(); // N+34
    chk({tag, ".done.rdy"}, data_resultRDY, 1);
    chk({tag, ".done.exc"}, data_exception, 0);
    chk({tag, ".done.busy"}, busy, 0);
    chk({tag, ".done.iterEn"}, iterEn, 0);
    chk({tag, ".done.cnt"}, iterCount, 0);
    chk({tag, ".done.nq"}, negateQuotient, nq);
    chk({tag, ".done.nr"}, negateRemainder, nr);
    tick(); // IDLE
    chk({tag, ".idle.rdy"}, data_resultRDY, 0);
    chk({tag, ".idle.busy"}, busy, 0);
    chk({tag, ".idle.nq"}, negateQuotient, nq);
  endtask

  initial begin
    int rdy_seen;
    reset = 1'b1; ctrl_DIV = 1'b0; signA = 1'b0; signB = 1'b0; divisorIsZero = 1'b0;
    #2;
    chk_all_zero("reset");
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_all_zero("idle");

    // Plain positive divide.
    start(0, 0, 0);
    run_full("basic", 0, 0);

    // Signs are captured at the request. Later input changes are ignored.
    ctrl_DIV = 1'b1; signA = 1'b1; signB = 1'b0; divisorIsZero = 1'b0;
    tick();
    ctrl_DIV = 1'b0; signA = 1'b0; signB = 1'b1;
    run_full("sign", 1, 1);

    // Divide by zero: LOAD then DONE with the exception flag set.
    start(0, 0, 1);
    divisorIsZero = 1'b0;
    chk("dz.n1.busy", busy, 1);
    chk("dz.n1.bootUp", bootUp, 1);
    chk("dz.n1.rdy", data_resultRDY, 0);
    chk("dz.n1.exc", data_exception, 0);
    tick();
    chk("dz.n2.rdy", data_resultRDY, 1);
    chk("dz.n2.exc", data_exception, 1);
    chk("dz.n2.busy", busy, 0);
    chk("dz.n2.iterEn", iterEn, 0);
    tick();
    chk("dz.n3.rdy", data_resultRDY, 0);
    chk("dz.n3.exc", data_exception, 0);
    chk("dz.n3.iterEn", iterEn, 0);

    // Restart at iterCount 10 with signB=1. Only one completion may follow.
    start(0, 0, 0);
    for (int i = 0; i < 11; i++) tick(); // ITER with count 10
    chk("rst10.cnt", iterCount, 10);
    rdy_seen = 0;
    ctrl_DIV = 1'b1; signA = 1'b0; signB = 1'b1;
    tick();
    ctrl_DIV = 1'b0; signB = 1'b0;
    run_full("restart", 1, 0);

    // Asynchronous reset at iterCount 20.
    start(0, 0, 0);
    for (int i = 0; i < 21; i++) tick();
    chk("areset.cnt", iterCount, 20);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("areset");
    tick();
    reset = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (data_resultRDY || busy) rdy_seen++;
    end
    chk("areset.no_activity", rdy_seen, 0);
    start(1, 1, 0);
    run_full("after_reset", 0, 1);

    // Back-to-back: a request in the DONE cycle.
    start(0, 0, 0);
    for (int i = 0; i < 33; i++) tick(); // N+34 = DONE
    chk("b2b.done1.rdy", data_resultRDY, 1);
    ctrl_DIV = 1'b1; signA = 1'b1; signB = 1'b1;
    tick();
    ctrl_DIV = 1'b0; signA = 1'b0; signB = 1'b0;
    chk("b2b.load.rdy", data_resultRDY, 0);
    run_full("b2b", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
